// File: rtl/frost32_ldst_pkg.sv
// Shared types and decode helpers for the frost32 load/store unit.
// The load/store type encoding follows the decoder's ordering of ops.
package frost32_ldst_pkg;

  typedef enum logic [2:0] {
    LD32  = 3'd0,
    LDU16 = 3'd1,
    LDS16 = 3'd2,
    LDU8  = 3'd3,
    LDS8  = 3'd4,
    ST32  = 3'd5,
    ST16  = 3'd6,
    ST8   = 3'd7
  } ldst_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } ldst_fsm_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  function automatic logic is_store(input ldst_type_e t);
    return (t == ST32) || (t == ST16) || (t == ST8);
  endfunction

  function automatic access_size_e access_size(input ldst_type_e t);
    case (t)
      LD32, ST32:         return SZ_WORD;
      LDU16, LDS16, ST16: return SZ_HALF;
      default:            return SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/frost32_ldst_lane_fmt.sv
// Combinational byte-lane formatting: store lane replication, byte enables,
// alignment check and load extraction with zero/sign extension.
module frost32_ldst_lane_fmt
  import frost32_ldst_pkg::*;
(
  input  logic [2:0]  ldst_type,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] ld_result
);

  ldst_type_e op;
  logic       sext;
  logic [7:0] lane_byte;
  logic [15:0] lane_half;

  assign op   = ldst_type_e'(ldst_type);
  assign sext = (op == LDS16) || (op == LDS8);

  always_comb begin
    be         = 4'h0;
    wdata      = 32'h0;
    misaligned = 1'b0;
    ld_result  = 32'h0;
    lane_byte  = rdata[{offset, 3'b000} +: 8];
    lane_half  = rdata[{offset[1], 4'b0000} +: 16];
    case (access_size(op))
      SZ_WORD: begin
        be         = 4'hF;
        misaligned = (offset != 2'b00);
        wdata      = st_data;
        ld_result  = rdata;
      end
      SZ_HALF: begin
        be         = 4'h3 << offset;
        misaligned = offset[0];
        wdata      = {2{st_data[15:0]}};
        ld_result  = {{16{sext & lane_half[15]}}, lane_half};
      end
      default: begin
        be         = 4'h1 << offset;
        wdata      = {4{st_data[7:0]}};
        ld_result  = {{24{sext & lane_byte[7]}}, lane_byte};
      end
    endcase
    // Loads drive a quiet write bus.
    if (!is_store(op)) wdata = 32'h0;
  end

endmodule

// File: rtl/frost32_ldst_unit.sv
// Load/store unit: one req/ack bus transaction per op, busy stalls upstream,
// done/wb pulses on completion, misalign and timeout errors.
module frost32_ldst_unit
  import frost32_ldst_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  ldst_type,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  rd_index,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [3:0]  wb_index,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  ldst_fsm_state_e          state_q, state_d;
  logic [2:0]               type_q;
  logic [1:0]               offset_q;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q;

  logic [2:0]  fmt_type;
  logic [1:0]  fmt_offset;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ld_result;
  logic        fmt_misaligned;

  logic in_idle, launch, reject, ack_hit, timeout_hit;

  // One formatter serves both phases: incoming op while idle, captured op during the access.
  assign in_idle    = (state_q == IDLE);
  assign fmt_type   = in_idle ? ldst_type : type_q;
  assign fmt_offset = in_idle ? addr[1:0] : offset_q;

  frost32_ldst_lane_fmt u_lane_fmt (
    .ldst_type  (fmt_type),
    .offset     (fmt_offset),
    .st_data    (st_data),
    .rdata      (mem_rdata),
    .be         (fmt_be),
    .wdata      (fmt_wdata),
    .misaligned (fmt_misaligned),
    .ld_result  (fmt_ld_result)
  );

  assign launch      = in_idle && start && !fmt_misaligned;
  assign reject      = in_idle && start && fmt_misaligned;
  assign ack_hit     = (state_q == ACCESS) && mem_ack;
  // A final-cycle ack takes priority over the timeout.
  assign timeout_hit = (state_q == ACCESS) && !mem_ack && (tmo_cnt_q == TMO_LAST);

  assign busy    = (state_q == ACCESS);
  assign mem_req = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = ACCESS;
      ACCESS:  if (ack_hit || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      type_q       <= 3'd0;
      offset_q     <= 2'd0;
      tmo_cnt_q    <= '0;
      done         <= 1'b0;
      wb_en        <= 1'b0;
      wb_index     <= 4'd0;
      wb_data      <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'h0;
      mem_wdata    <= 32'h0;
    end else begin
      state_q      <= state_d;
      done         <= 1'b0;
      wb_en        <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;

      if (reject) begin
        misalign_err <= 1'b1;
        done         <= 1'b1;
      end

      if (launch) begin
        type_q    <= ldst_type;
        offset_q  <= addr[1:0];
        wb_index  <= rd_index;
        tmo_cnt_q <= '0;
        mem_we    <= is_store(ldst_type_e'(ldst_type));
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= fmt_be;
        mem_wdata <= fmt_wdata;
      end

      if (ack_hit) begin
        done <= 1'b1;
        if (!is_store(ldst_type_e'(type_q))) begin
          wb_en   <= 1'b1;
          wb_data <= fmt_ld_result;
        end
      end else if (timeout_hit) begin
        bus_err <= 1'b1;
        done    <= 1'b1;
      end else if (state_q == ACCESS) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

endmodule
